seg7_scan_ctrl: RTL

//  Parametrised multiplexed 7-segment driver, successor of the fixed 4-digit scanner.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner:
// blank pattern, hex-to-gfedcba table and counter width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Width for a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Active-low gfedcba patterns for common-anode digits.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
import seg7_pkg::*;

module seg7_hex_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nib);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit common-anode 7-segment scanner with dead time, PWM brightness,
// per-digit blank/blink/dp masks, leading-zero blanking and double-buffered data.
import seg7_pkg::*;

module seg7_scan_ctrl #(
  parameter int N_DIG        = 4,
  parameter int DIV          = 50000,
  parameter int DEAD         = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               load,
  input  logic [4*N_DIG-1:0] dat,
  input  logic [N_DIG-1:0]   dp_mask,
  input  logic [N_DIG-1:0]   blank_mask,
  input  logic [N_DIG-1:0]   blink_mask,
  input  logic               lz_en,
  input  logic [3:0]         bright,
  output logic [N_DIG-1:0]   an,
  output logic [6:0]         seg,
  output logic               dp,
  output logic               frame_tick
);

  localparam int SW     = cnt_w(DIV);
  localparam int DW     = cnt_w(N_DIG);
  localparam int FW     = cnt_w(BLINK_FRAMES);
  localparam int ON_LEN = (DIV - DEAD) / 16;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIG - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] slot_cnt_reg, slot_cnt_next;
  logic [DW-1:0] dig_idx_reg, dig_idx_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          blink_ph_reg, blink_ph_next;

  logic [4*N_DIG-1:0] dat_sh_reg;
  logic [N_DIG-1:0]   dp_sh_reg, blank_sh_reg, blink_sh_reg;

  logic [N_DIG-1:0] an_reg;
  logic [6:0]       seg_reg;
  logic             dp_reg;
  logic             frame_tick_reg;

  logic slot_wrap, dig_wrap, frame_wrap;

  assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
  assign dig_wrap   = slot_wrap && (dig_idx_reg == DIG_LAST);
  assign frame_wrap = dig_wrap && (frame_cnt_reg == FRAME_LAST);

  always_comb begin
    slot_cnt_next  = slot_cnt_reg;
    dig_idx_next   = dig_idx_reg;
    frame_cnt_next = frame_cnt_reg;
    blink_ph_next  = blink_ph_reg;
    if (ce) begin
      slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
      if (slot_wrap) begin
        dig_idx_next = (dig_idx_reg == DIG_LAST) ? '0 : dig_idx_reg + 1'b1;
      end
      if (dig_wrap) begin
        frame_cnt_next = frame_wrap ? '0 : frame_cnt_reg + 1'b1;
      end
      if (frame_wrap) begin
        blink_ph_next = ~blink_ph_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg  <= '0;
      dig_idx_reg   <= '0;
      frame_cnt_reg <= '0;
      blink_ph_reg  <= 1'b0;
    end else begin
      slot_cnt_reg  <= slot_cnt_next;
      dig_idx_reg   <= dig_idx_next;
      frame_cnt_reg <= frame_cnt_next;
      blink_ph_reg  <= blink_ph_next;
    end
  end

  // Shadow copy is independent of ce so the datapath can update a frozen display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_sh_reg   <= '0;
      dp_sh_reg    <= '0;
      blank_sh_reg <= '0;
      blink_sh_reg <= '0;
    end else if (load) begin
      dat_sh_reg   <= dat;
      dp_sh_reg    <= dp_mask;
      blank_sh_reg <= blank_mask;
      blink_sh_reg <= blink_mask;
    end
  end

  // hi_zero[i]: nibble i and every nibble above it are zero.
  logic [N_DIG-1:1] hi_zero;

  always_comb begin
    hi_zero = '0;
    hi_zero[N_DIG-1] = (dat_sh_reg[4*N_DIG-1 -: 4] == 4'h0);
    for (int i = N_DIG - 2; i >= 1; i--) begin
      hi_zero[i] = hi_zero[i+1] && (dat_sh_reg[4*i +: 4] == 4'h0);
    end
  end

  logic [N_DIG-1:0] dark;
  logic [N_DIG-1:0] an_lit;

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
    logic lz_dark;
    if (gi == 0) begin : g_units
      assign lz_dark = 1'b0;
    end else begin : g_upper
      assign lz_dark = lz_en && hi_zero[gi];
    end
    assign dark[gi]   = blank_sh_reg[gi] || (blink_sh_reg[gi] && blink_ph_reg) || lz_dark;
    assign an_lit[gi] = (dig_idx_reg != DW'(gi));
  end

  logic [3:0] cur_nib;
  logic       cur_dark;
  logic       cur_dp;
  logic [6:0] cur_seg;

  always_comb begin
    cur_nib  = 4'h0;
    cur_dark = 1'b1;
    cur_dp   = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (dig_idx_reg == DW'(i)) begin
        cur_nib  = dat_sh_reg[4*i +: 4];
        cur_dark = dark[i];
        cur_dp   = dp_sh_reg[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // Lit window opens after the dead gap and grows by ON_LEN per brightness step.
  logic [31:0] slot_ext, win_end;
  logic        in_win, lit;

  assign slot_ext = 32'(slot_cnt_reg);
  assign win_end  = 32'(DEAD) + 32'(ON_LEN) * (32'(bright) + 32'd1);
  assign in_win   = (slot_ext >= 32'(DEAD)) && (slot_ext < win_end);
  assign lit      = in_win && !cur_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg         <= '1;
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= ce && dig_wrap;
      if (ce) begin
        if (lit) begin
          an_reg  <= an_lit;
          seg_reg <= cur_seg;
          dp_reg  <= ~cur_dp;
        end else begin
          an_reg  <= '1;
          seg_reg <= SEG_OFF;
          dp_reg  <= 1'b1;
        end
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_tick = frame_tick_reg;

endmodule
